// File: rtl/bit_serial_core.sv
// Bit-serial accumulator machine: each accepted instruction runs LSB first over
// WIDTH shift cycles through one full adder, then pulses o_done for a cycle.
module bit_serial_core #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [2:0]              i_op,
   input  logic [$clog2(NREG)-1:0] i_rd,
   input  logic [$clog2(NREG)-1:0] i_rs,
   input  logic [WIDTH-1:0]        i_data_switch,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [WIDTH-1:0]        o_acc,
   output logic [WIDTH-1:0]        o_y,
   output logic                    o_carry
);
   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_CLR   = 3'd5;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [RW-1:0]     rd_q;
   logic [RW-1:0]     rs_q;
   logic [WIDTH-1:0]  sw_q;
   logic [WIDTH-1:0]  acc;
   logic              carry;
   logic              carry_out;
   logic [WIDTH-1:0]  regs [NREG];

   logic              last;
   logic              addend;
   logic [1:0]        fa;

   // Returns {carry, sum} of a single-bit full add.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   assign last   = (cnt == CNT_LAST);
   // SUB feeds the inverted source bit; the +1 comes from the carry preset.
   assign addend = regs[rs_q][0] ^ (op_q == OP_SUB);
   assign fa     = full_add(acc[0], addend, carry);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         IDLE:  if (i_start) state_nxt = SHIFT;
         SHIFT: begin
            o_busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            o_busy    = 1'b1;
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt       <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         rs_q      <= '0;
         sw_q      <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         carry_out <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         case (state)
            IDLE: if (i_start) begin
               op_q  <= i_op;
               rd_q  <= i_rd;
               rs_q  <= i_rs;
               sw_q  <= i_data_switch;
               carry <= (i_op == OP_SUB);
               cnt   <= '0;
            end
            SHIFT: begin
               cnt  <= last ? '0 : cnt + CW'(1);
               sw_q <= {sw_q[0], sw_q[WIDTH-1:1]};
               case (op_q)
                  OP_LOAD: regs[rd_q] <= {sw_q[0], regs[rd_q][WIDTH-1:1]};
                  OP_ADD, OP_SUB: begin
                     acc        <= {fa[0], acc[WIDTH-1:1]};
                     carry      <= fa[1];
                     regs[rs_q] <= {regs[rs_q][0], regs[rs_q][WIDTH-1:1]};
                     if (last) carry_out <= fa[1];
                  end
                  OP_STORE: begin
                     regs[rd_q] <= {acc[0], regs[rd_q][WIDTH-1:1]};
                     acc        <= {acc[0], acc[WIDTH-1:1]};
                  end
                  OP_CLR:  acc <= {1'b0, acc[WIDTH-1:1]};
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign o_acc   = acc;
   assign o_y     = regs[0];
   assign o_carry = carry_out;

endmodule

// File: tb/tb_bit_serial_core.sv
// Bench for bit_serial_core (WIDTH=8, NREG=4): directed vector table, multi-cycle
// corner sequences and random instructions against an arithmetic reference model.
module tb_bit_serial_core;
   localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3;
   localparam logic [2:0] STORE = 3'd4, CLR = 3'd5;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic [2:0] i_op = '0;
   logic [1:0] i_rd = '0;
   logic [1:0] i_rs = '0;
   logic [7:0] i_data_switch = '0;
   logic       o_busy, o_done, o_carry;
   logic [7:0] o_acc, o_y;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_acc;
   logic [7:0] m_r [4];
   logic       m_c;

   typedef struct {
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] sw;
      logic [7:0] acc;
      logic [7:0] y;
      logic       c;
   } vec_t;

   vec_t tbl [24];

   bit_serial_core #(.WIDTH(8), .NREG(4)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_rd(i_rd),
      .i_rs(i_rs), .i_data_switch(i_data_switch), .o_busy(o_busy), .o_done(o_done),
      .o_acc(o_acc), .o_y(o_y), .o_carry(o_carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = '0;
      m_c   = 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
   endtask

   task automatic model_apply(input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [7:0] sw);
      logic [8:0] t;
      case (op)
         LOAD:  m_r[rd] = sw;
         ADD: begin
            t = {1'b0, m_acc} + {1'b0, m_r[rs]};
            m_acc = t[7:0];
            m_c   = t[8];
         end
         SUB: begin
            t = {1'b0, m_acc} + {1'b0, ~m_r[rs]} + 9'd1;
            m_acc = t[7:0];
            m_c   = t[8];
         end
         STORE: m_r[rd] = m_acc;
         CLR:   m_acc = '0;
         default: ;
      endcase
   endtask

   // Issues one instruction, scrambles the operand inputs while it is in flight,
   // and waits (bounded) for o_done. Latency counts edges from the accepting one.
   task automatic exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] sw, input bit hold, input bit nowait);
      int n;
      bit seen;
      bit busy_ok;
      if (!nowait) @(negedge clk);
      check("idle_busy", o_busy, 1'b0);
      i_start = 1'b1;
      i_op = op; i_rd = rd; i_rs = rs; i_data_switch = sw;
      n = 0; seen = 0; busy_ok = 1;
      while (!seen && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!hold) i_start = 1'b0;
         i_op = 3'($urandom); i_rd = 2'($urandom); i_rs = 2'($urandom);
         i_data_switch = 8'($urandom);
         if (o_busy !== 1'b1) busy_ok = 0;
         if (o_done === 1'b1) seen = 1;
      end
      check("done_latency", n, 9);
      check("busy_in_flight", busy_ok, 1'b1);
      model_apply(op, rd, rs, sw);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_acc"}, o_acc, m_acc);
      check({tag, "_y"}, o_y, m_r[0]);
      check({tag, "_carry"}, o_carry, m_c);
   endtask

   initial begin
      tbl[0]  = '{LOAD,  2'd0, 2'd0, 8'hA5, 8'h00, 8'hA5, 1'b0};
      tbl[1]  = '{LOAD,  2'd1, 2'd0, 8'h0F, 8'h00, 8'hA5, 1'b0};
      tbl[2]  = '{ADD,   2'd0, 2'd1, 8'h00, 8'h0F, 8'hA5, 1'b0};
      tbl[3]  = '{ADD,   2'd0, 2'd1, 8'h00, 8'h1E, 8'hA5, 1'b0};
      tbl[4]  = '{LOAD,  2'd2, 2'd0, 8'hF0, 8'h1E, 8'hA5, 1'b0};
      tbl[5]  = '{ADD,   2'd0, 2'd2, 8'h00, 8'h0E, 8'hA5, 1'b1};
      tbl[6]  = '{CLR,   2'd0, 2'd0, 8'h00, 8'h00, 8'hA5, 1'b1};
      tbl[7]  = '{LOAD,  2'd1, 2'd0, 8'h07, 8'h00, 8'hA5, 1'b1};
      tbl[8]  = '{LOAD,  2'd3, 2'd0, 8'h05, 8'h00, 8'hA5, 1'b1};
      tbl[9]  = '{ADD,   2'd0, 2'd3, 8'h00, 8'h05, 8'hA5, 1'b0};
      tbl[10] = '{SUB,   2'd0, 2'd1, 8'h00, 8'hFE, 8'hA5, 1'b0};
      tbl[11] = '{CLR,   2'd0, 2'd0, 8'h00, 8'h00, 8'hA5, 1'b0};
      tbl[12] = '{ADD,   2'd0, 2'd1, 8'h00, 8'h07, 8'hA5, 1'b0};
      tbl[13] = '{LOAD,  2'd3, 2'd0, 8'h3C, 8'h07, 8'hA5, 1'b0};
      tbl[14] = '{CLR,   2'd0, 2'd0, 8'h00, 8'h00, 8'hA5, 1'b0};
      tbl[15] = '{ADD,   2'd0, 2'd3, 8'h00, 8'h3C, 8'hA5, 1'b0};
      tbl[16] = '{STORE, 2'd0, 2'd0, 8'h00, 8'h3C, 8'h3C, 1'b0};
      tbl[17] = '{CLR,   2'd0, 2'd0, 8'h00, 8'h00, 8'h3C, 1'b0};
      tbl[18] = '{NOP,   2'd0, 2'd1, 8'hFF, 8'h00, 8'h3C, 1'b0};
      tbl[19] = '{3'd6,  2'd0, 2'd1, 8'hFF, 8'h00, 8'h3C, 1'b0};
      tbl[20] = '{ADD,   2'd0, 2'd3, 8'h00, 8'h3C, 8'h3C, 1'b0};
      tbl[21] = '{SUB,   2'd0, 2'd3, 8'h00, 8'h00, 8'h3C, 1'b1};
      tbl[22] = '{3'd7,  2'd0, 2'd2, 8'h81, 8'h00, 8'h3C, 1'b1};
      tbl[23] = '{STORE, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1};

      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_acc", o_acc, 8'h00);
      check("rst_y", o_y, 8'h00);
      check("rst_carry", o_carry, 1'b0);

      for (int i = 0; i < 24; i++) begin
         exec(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].sw, 1'b0, 1'b0);
         check($sformatf("tbl%0d_acc", i), o_acc, tbl[i].acc);
         check($sformatf("tbl%0d_y", i), o_y, tbl[i].y);
         check($sformatf("tbl%0d_carry", i), o_carry, tbl[i].c);
      end

      // i_start held high throughout: each instruction runs once, the next one
      // is accepted from IDLE the cycle after o_done.
      exec(LOAD, 2'd0, 2'd0, 8'h99, 1'b1, 1'b0);
      check_model("hold_a");
      exec(ADD, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0);
      check_model("hold_b");
      exec(ADD, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0);
      check_model("hold_c");
      check("hold_c_acc_const", o_acc, 8'h89);

      for (int k = 0; k < 150; k++) begin
         exec(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom), 1'b0, 1'b0);
         check_model($sformatf("rnd%0d", k));
      end

      // Build non-zero acc/R0/carry, then reset in the middle of an ADD.
      exec(LOAD, 2'd0, 2'd0, 8'h5A, 1'b0, 1'b0);
      exec(LOAD, 2'd1, 2'd0, 8'hFF, 1'b0, 1'b0);
      exec(LOAD, 2'd2, 2'd0, 8'h01, 1'b0, 1'b0);
      exec(CLR, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
      exec(ADD, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0);
      exec(ADD, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0);
      exec(ADD, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0);
      check_model("pre_rst");
      check("pre_rst_acc_const", o_acc, 8'h01);

      @(negedge clk);
      i_start = 1'b1; i_op = ADD; i_rs = 2'd1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_busy", o_busy, 1'b0);
      check("midrst_done", o_done, 1'b0);
      check("midrst_acc", o_acc, 8'h00);
      check("midrst_y", o_y, 8'h00);
      check("midrst_carry", o_carry, 1'b0);
      i_rst = 1'b0;
      model_reset();
      exec(3'd7, 2'd0, 2'd1, 8'hFF, 1'b0, 1'b1);
      check_model("post_rst_op7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bit_serial_core.md
BIT_SERIAL_CORE -- requirements
Module: bit_serial_core

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the data word width in bits; legal range is 2..32.
REQ-002 The parameter NREG SHALL default to 4 and set the number of general-purpose registers; it SHALL be a power of two, 2..16.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 The port i_clk SHALL be an input of width 1 and serve as the clock; all state changes on its rising edge.
REQ-005 The port i_rst SHALL be an input of width 1 and serve as the synchronous active-high reset.
REQ-006 The port i_start SHALL be an input of width 1 that requests execution of one instruction.
REQ-007 The port i_op SHALL be an input of width 3 that carries the opcode: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 STORE, 5 CLR; opcodes 6 and 7 are reserved.
REQ-008 The port i_rd SHALL be an input of width log2(NREG) that selects the destination register for LOAD and STORE.
REQ-009 The port i_rs SHALL be an input of width log2(NREG) that selects the source register for ADD and SUB.
REQ-010 The port i_data_switch SHALL be an input of width WIDTH that supplies the operand for LOAD.
REQ-011 The port o_busy SHALL be an output of width 1 that is high while an instruction executes.
REQ-012 The port o_done SHALL be an output of width 1 that gives a one-cycle completion pulse.
REQ-013 The port o_acc SHALL be an output of width WIDTH that presents the accumulator contents.
REQ-014 The port o_y SHALL be an output of width WIDTH that presents register 0 contents.
REQ-015 The port o_carry SHALL be an output of width 1 that presents the final carry of the last ADD or SUB.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 Transitions SHALL be: IDLE->SHIFT on i_start=1; SHIFT->DONE after exactly WIDTH cycles; DONE->IDLE unconditionally.
REQ-018 On start acceptance, i_op, i_rd, i_rs and i_data_switch SHALL be captured; later changes to these inputs SHALL NOT affect the instruction in flight.
REQ-019 i_start SHALL be ignored outside IDLE; no queuing.
REQ-020 o_busy SHALL be 1 in SHIFT and DONE, 0 in IDLE; o_done SHALL be 1 only in DONE.
REQ-021 o_done SHALL rise WIDTH+1 cycles after the accepting edge, for every opcode including NOP and reserved.
REQ-022 A bit counter of width ceil(log2(WIDTH)) SHALL count 0..WIDTH-1 in SHIFT and clear on SHIFT exit.
REQ-023 Datapath SHALL be bit-serial, LSB first: each SHIFT cycle, each affected register SHALL rotate right one bit, consuming bit 0 and inserting the new bit at bit WIDTH-1.
REQ-024 Unaffected registers and the accumulator SHALL hold their values.
REQ-025 LOAD SHALL write the captured switch word into R[rd], one bit per cycle.
REQ-026 ADD SHALL compute acc <= acc + R[rs] mod 2^WIDTH; the carry flop SHALL start at 0; R[rs] SHALL rotate back to its original value.
REQ-027 SUB SHALL compute acc <= acc - R[rs] mod 2^WIDTH as acc + ~R[rs] + 1; the carry flop SHALL start at 1.
REQ-028 STORE SHALL copy acc into R[rd]; acc SHALL rotate back unchanged.
REQ-029 CLR SHALL shift zeros into acc.
REQ-030 NOP and reserved opcodes SHALL change no register, accumulator or o_carry.
REQ-031 o_carry SHALL update in DONE with the final carry for ADD and SUB only; for SUB, 1 means no borrow.
REQ-032 When an instruction completes, o_acc and o_y SHALL be word-stable from DONE onward; intermediate values during SHIFT are unspecified.

Reset
REQ-033 i_rst=1 SHALL take priority in any state: FSM->IDLE, counter, acc, all registers, carry flop and o_carry to 0; o_busy=0, o_done=0.
REQ-034 A reset mid-SHIFT SHALL abort the instruction with no partial result retained, and i_start SHALL be accepted on the first cycle after reset is released.

Verification (WIDTH=8, NREG=4)
REQ-035 Scenario: LOAD rd=0, switch=0xA5 -> o_done on cycle 9 after start; o_y=0xA5; o_carry unchanged.
REQ-036 Scenario: LOAD R1=0x0F, ADD rs=1 twice from acc=0 -> o_acc=0x1E, o_carry=0; then LOAD R2=0xF0, ADD rs=2 -> o_acc=0x0E, o_carry=1.
REQ-037 Scenario: acc=0x05, R1=0x07, SUB rs=1 -> o_acc=0xFE, o_carry=0; R1 still 0x07.
REQ-038 Scenario: STORE rd=0 with acc=0x3C -> o_y=0x3C and o_acc=0x3C; then CLR -> o_acc=0x00, o_y=0x3C.
REQ-039 Scenario: i_start held high and ops changed during SHIFT -> only the first instruction executes; the next start is accepted in IDLE one cycle after o_done.
REQ-040 Scenario: reset asserted on counter=4 of an ADD -> all outputs 0 next cycle; opcode 7 afterwards -> o_done after 9 cycles with no state change.
